decode_issue_stage: RTL

Parametrised decode/issue stage for the pipelined RV32 core. It holds the register file, generates the immediate and a compact instruction classification, and tracks in-flight destination registers on a scoreboard. It stalls on RAW/WAW hazards and registers the decoded instruction into an ID/EX register with a valid/ready handshake and a flush. It sits between the IF/ID register and the execute stage. Writeback from the final stage returns on a dedicated port.

---
 rtl/decode_issue_stage.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_issue_stage.sv
// -----------------------------------------------------------------------------
// decode_issue_stage
//
// Decode/issue stage of the pipelined RV32 core. Decodes the instruction held
// in IF/ID, reads the register file (with write-through bypass from the
// writeback port), tracks in-flight destinations on a scoreboard, stalls on
// RAW/WAW hazards and registers the decoded instruction into ID/EX.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. in_ready is combinational and never depends on in_valid.
// While out_valid is 1 and out_ready is 0, every ex_* output holds.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake for instr_d / pc_d
//   instr_d, pc_d            instruction word and its address
//   flush                    kill ID/EX contents and block issue this cycle
//   wb_en, wb_rd, wb_data    writeback port from the final stage
//   out_valid / out_ready    downstream handshake for the ex_* bundle
//   ex_*                     registered decoded instruction and operands
//   busy_vec                 scoreboard, one bit per architectural register
// -----------------------------------------------------------------------------
module decode_issue_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr_d,
    input  logic [DATA_WIDTH-1:0] pc_d,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [4:0]            ex_rd,
    output logic                  ex_rd_we,
    output logic [6:0]            ex_opcode,
    output logic [2:0]            ex_funct3,
    output logic                  ex_funct7_5,
    output logic                  ex_illegal,
    output logic [REG_COUNT-1:0]  busy_vec
);

    localparam int         IDX_W     = $clog2(REG_COUNT);
    localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ------------------------------------------------------------------ state
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  busy_q;
    logic [REG_COUNT-1:0]  busy_d;

    // ----------------------------------------------------------------- decode
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        legal_op;
    logic        writes_rd;
    logic        reads_rs1;
    logic        reads_rs2;
    logic [31:0] imm32;

    assign opcode = instr_d[6:0];
    assign rd     = instr_d[11:7];
    assign rs1    = instr_d[19:15];
    assign rs2    = instr_d[24:20];

    always_comb begin
        legal_op  = 1'b1;
        writes_rd = 1'b0;
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        imm32     = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                writes_rd = 1'b1;
                imm32     = {instr_d[31:12], 12'b0};
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                imm32     = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20],
                             instr_d[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                imm32     = {{20{instr_d[31]}}, instr_d[31:20]};
            end
            OPC_BRANCH: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
                imm32     = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25],
                             instr_d[11:8], 1'b0};
            end
            OPC_STORE: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
                imm32     = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            default: legal_op = 1'b0;
        endcase
    end

    // Index range checks only matter for RV32E (REG_COUNT = 16).
    logic rs1_ok;
    logic rs2_ok;
    logic rd_ok;
    logic wb_ok;
    assign rs1_ok = {1'b0, rs1}   < REG_LIMIT;
    assign rs2_ok = {1'b0, rs2}   < REG_LIMIT;
    assign rd_ok  = {1'b0, rd}    < REG_LIMIT;
    assign wb_ok  = {1'b0, wb_rd} < REG_LIMIT;

    logic illegal;
    logic rd_we;
    logic uses_rs1;
    logic uses_rs2;
    assign illegal  = !legal_op
                    | (reads_rs1 & !rs1_ok)
                    | (reads_rs2 & !rs2_ok)
                    | (writes_rd & !rd_ok);
    // An illegal instruction still issues, but must never touch the scoreboard.
    assign rd_we    = writes_rd & (rd != 5'd0) & !illegal;
    assign uses_rs1 = reads_rs1 & !illegal;
    assign uses_rs2 = reads_rs2 & !illegal;

    // ---------------------------------------------------- register file read
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1 != 5'd0 && rs1_ok) begin
            rs1_data = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1[IDX_W-1:0]];
        end
        if (rs2 != 5'd0 && rs2_ok) begin
            rs2_data = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2[IDX_W-1:0]];
        end
    end

    // ------------------------------------------------------- hazard / issue
    // A writeback this cycle releases its register immediately; the bypass
    // above supplies the value, so dependents may issue in the same cycle.
    logic [REG_COUNT-1:0] wb_mask;
    logic [REG_COUNT-1:0] busy_eff;

    always_comb begin
        wb_mask = '0;
        if (wb_en && wb_ok) begin
            wb_mask[wb_rd[IDX_W-1:0]] = 1'b1;
        end
    end

    assign busy_eff = busy_q & ~wb_mask;

    logic hazard;
    logic fire;
    assign hazard = (uses_rs1 & rs1_ok & busy_eff[rs1[IDX_W-1:0]])
                  | (uses_rs2 & rs2_ok & busy_eff[rs2[IDX_W-1:0]])
                  | (rd_we    & rd_ok  & busy_eff[rd[IDX_W-1:0]]);

    assign in_ready = !rst & !flush & !hazard & (!out_valid | out_ready);
    assign fire     = in_valid & in_ready;

    // ----------------------------------------------------------- scoreboard
    always_comb begin
        busy_d = busy_q & ~wb_mask;
        // A flushed instruction will never write back, so release its rd.
        if (flush && out_valid && ex_rd_we) begin
            busy_d[ex_rd[IDX_W-1:0]] = 1'b0;
        end
        // Set after clears: an issue to the register being written back wins.
        if (fire && rd_we) begin
            busy_d[rd[IDX_W-1:0]] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // --------------------------------------------------- register file write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_rd != 5'd0 && wb_ok) begin
            regs[wb_rd[IDX_W-1:0]] <= wb_data;
        end
    end

    // ----------------------------------------------------------- ID/EX stage
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_rd_we    <= 1'b0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7_5 <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid   <= 1'b1;
            ex_pc       <= pc_d;
            ex_rs1_data <= rs1_data;
            ex_rs2_data <= rs2_data;
            ex_imm      <= DATA_WIDTH'($signed(imm32));
            ex_rd       <= rd;
            ex_rd_we    <= rd_we;
            ex_opcode   <= opcode;
            ex_funct3   <= instr_d[14:12];
            ex_funct7_5 <= instr_d[30];
            ex_illegal  <= illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
